// File: rtl/data_mem_responder_if.sv
// Handshake bundle between the core's data-memory port and the memory responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_zero_ext;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_write, req_size, req_zero_ext, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_size, req_zero_ext, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-lane stores, sign/zero-extended loads, and one
// outstanding request answered after a fixed latency under valid/ready backpressure.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic                  clk,
  input logic                  rst,
  data_mem_responder_if.slave  bus
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hold_rdata;
  logic        hold_err;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             req_err;
  logic [IDX_W-1:0] idx;
  logic [31:0]      word;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [31:0]      load_data;
  logic [31:0]      lane_data;
  logic [3:0]       lane_en;

  always_comb begin
    accept    = bus.req_valid & bus.req_ready;
    req_err   = (bus.req_size == 2'b10)
              | ((bus.req_size == 2'b01) & bus.req_addr[0])
              | ((bus.req_size == 2'b11) & (bus.req_addr[1:0] != 2'b00))
              | ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));
    idx       = bus.req_addr[IDX_W+1:2];
    word      = mem[idx];
    sel_half  = bus.req_addr[1] ? word[31:16] : word[15:0];
    sel_byte  = word[7:0];
    case (bus.req_addr[1:0])
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      2'd3:    sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase

    load_data = word;
    lane_data = bus.req_wdata;
    lane_en   = 4'b1111;
    case (bus.req_size)
      2'b00: begin
        load_data = bus.req_zero_ext ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
        lane_data = {4{bus.req_wdata[7:0]}};
        lane_en   = 4'b0001 << bus.req_addr[1:0];
      end
      2'b01: begin
        load_data = bus.req_zero_ext ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
        lane_data = {2{bus.req_wdata[15:0]}};
        lane_en   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        load_data = word;
        lane_data = bus.req_wdata;
        lane_en   = 4'b1111;
      end
    endcase
  end

  // Array is deliberately not reset; stores commit on the accept edge itself.
  always_ff @(posedge clk) begin
    if (accept && bus.req_write && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  // The counter tracks cycles spent in WAIT so resp_valid rises LATENCY edges after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      hold_rdata     <= 32'h0;
      hold_err       <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'h0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            state         <= S_WAIT;
            cnt           <= 4'd0;
            bus.req_ready <= 1'b0;
            hold_rdata    <= (req_err || bus.req_write) ? 32'h0 : load_data;
            hold_err      <= req_err;
          end
        end
        S_WAIT: begin
          if (cnt == 4'(LATENCY - 1)) begin
            state          <= S_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= hold_rdata;
            bus.resp_err   <= hold_err;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            state          <= S_IDLE;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: stimulus pushes expected responses into a
// scoreboard queue that a negedge monitor pops and compares.
module tb_data_mem_responder;
  localparam int LATENCY = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic zx,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    int   n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) begin
      checkOutput("req_ready_timeout", {31'h0, bus.req_ready}, 32'h1);
      return;
    end
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = size;
    bus.req_zero_ext = zx;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk); #1;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.acc   = cyc;
    sb.push_back(e);
    // Garbage after the accept edge must be ignored by the responder.
    bus.req_valid = 1'b0;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0000_0010;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_size  = 2'b11;
  endtask

  // Monitor: latency on the rising edge of resp_valid, data/err every valid cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.resp_valid && !prev_valid) begin
        if (sb.size() == 0) checkOutput("unexpected_resp", 32'h1, 32'h0);
        else checkOutput("latency", 32'(cyc - sb[0].acc), 32'(LATENCY));
      end
      if (bus.resp_valid && sb.size() > 0) begin
        checkOutput("resp_rdata", bus.resp_rdata, sb[0].rdata);
        checkOutput("resp_err", {31'h0, bus.resp_err}, {31'h0, sb[0].err});
        if (bus.resp_ready) void'(sb.pop_front());
      end
    end
    prev_valid = bus.resp_valid;
  end

  initial begin
    int n;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b11;
    bus.req_zero_ext = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.resp_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", {31'h0, bus.req_ready}, 32'h1);
    checkOutput("reset_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    checkOutput("reset_resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("reset_resp_err", {31'h0, bus.resp_err}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store/load, then byte and half lane behaviour.
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h13, 32'h80, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00001234, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000BE, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);

    // Backpressure: response held for 5 cycles with req_ready low.
    n = 0;
    while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus.resp_ready = 1'b0;
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
    n = 0;
    while (!bus.resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    checkOutput("stall_valid_seen", {31'h0, bus.resp_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_req_ready", {31'h0, bus.req_ready}, 32'h0);
      checkOutput("stall_resp_valid", {31'h0, bus.resp_valid}, 32'h1);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_hs_req_ready", {31'h0, bus.req_ready}, 32'h1);
    checkOutput("post_hs_resp_valid", {31'h0, bus.resp_valid}, 32'h0);

    // Reset while waiting drops the pending response.
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);
    rst = 1'b1;
    #1;
    sb.delete();
    checkOutput("midrst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    checkOutput("midrst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("postrst_no_resp", {31'h0, bus.resp_valid}, 32'h0);
    end
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h1234BEEF, 1'b0);

    // Error cases leave the array untouched; last word is in range.
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h0, 32'h11223344, 32'h0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h11223344, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h1000, 32'hCAFEF00D, 32'h0, 1'b1);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'hFFC, 32'hA5A5C3C3, 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'hFFC, 32'h0, 32'hA5A5C3C3, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'hFFF, 32'h0, 32'h000000A5, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'h0);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
